// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogrammed sequencer: microword layout,
// sequencing opcodes, FSM states and the mask applied to stalled control words.
package seq_pkg;

    localparam int CWR_W          = 34;
    localparam int MW_W           = 47;
    localparam int SEQ_OP_LSB     = 44;
    localparam int NEXT_ADDR_LSB  = 36;
    localparam int LD_IR_BIT      = 35;
    localparam int WAIT_MEM_BIT   = 34;
    localparam int RF_LD_LSB      = 12;
    localparam int FETCH_ADDR     = 0;
    localparam int DISPATCH_SHIFT = 4;

    typedef enum logic [2:0] {
        SEQ_NEXT     = 3'd0,
        SEQ_JUMP     = 3'd1,
        SEQ_DISPATCH = 3'd2,
        SEQ_BRZ      = 3'd3,
        SEQ_BRC      = 3'd4,
        SEQ_FETCH    = 3'd5,
        SEQ_HALT     = 3'd6,
        SEQ_RSVD     = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Clearing the register-file load pair keeps a repeated stalled word harmless.
    function automatic logic [CWR_W-1:0] mask_rf_load(input logic [CWR_W-1:0] cw);
        logic [CWR_W-1:0] m;
        m = cw;
        m[RF_LD_LSB +: 2] = 2'b00;
        return m;
    endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Sequencer bus: datapath/memory inputs, control-store load port and the
// control outputs consumed by control_line_gen.
interface micro_sequencer_if import seq_pkg::*; #(parameter int UPC_W = 8);

    logic                run;
    logic                mem_ready;
    logic [15:0]         mem_rdata;
    logic                zero_flag;
    logic                carry_flag;
    logic                ucode_we;
    logic [UPC_W-1:0]    ucode_waddr;
    logic [MW_W-1:0]     ucode_wdata;
    logic [15:0]         ins;
    logic [CWR_W-1:0]    cwr;
    logic [UPC_W-1:0]    upc;
    logic                busy;
    logic                halted;
    logic [15:0]         retired;

    modport master (
        output run, mem_ready, mem_rdata, zero_flag, carry_flag,
               ucode_we, ucode_waddr, ucode_wdata,
        input  ins, cwr, upc, busy, halted, retired
    );

    modport slave (
        input  run, mem_ready, mem_rdata, zero_flag, carry_flag,
               ucode_we, ucode_waddr, ucode_wdata,
        output ins, cwr, upc, busy, halted, retired
    );

endinterface

// File: rtl/micro_sequencer_ucode_rom.sv
// Control store: 2^UPC_W microwords, combinational read at the current upc.
// The boot image is written through the load port before the core is started.
module ucode_rom import seq_pkg::*; #(parameter int UPC_W = 8) (
    input  logic             clk,
    input  logic             we,
    input  logic [UPC_W-1:0] waddr,
    input  logic [MW_W-1:0]  wdata,
    input  logic [UPC_W-1:0] raddr,
    output logic [MW_W-1:0]  rdata
);

    localparam int DEPTH = 1 << UPC_W;

    logic [MW_W-1:0] mem_r [DEPTH];

    // Image load port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer: upc/IR/retire-count registers, next-address
// selection, opcode dispatch, flag branches and memory-wait stalls.
module micro_sequencer import seq_pkg::*; #(parameter int UPC_W = 8) (
    input  logic clk,
    input  logic reset,
    micro_sequencer_if.slave bus
);

    state_e           state_r, state_nx_s;
    logic [UPC_W-1:0] upc_r, upc_nx_s, upc_inc_s, next_addr_s;
    logic [15:0]      ins_r, ins_nx_s, retired_r, retired_nx_s;
    logic [MW_W-1:0]  uword_s;
    seq_op_e          seq_op_s;
    logic             ld_ir_s, wait_mem_s, stall_s, adv_s, busy_s, halted_s;
    logic [CWR_W-1:0] cw_s, cwr_s;
    logic [3:0]       op_s;

    ucode_rom #(.UPC_W(UPC_W)) u_rom (
        .clk   (clk),
        .we    (bus.ucode_we),
        .waddr (bus.ucode_waddr),
        .wdata (bus.ucode_wdata),
        .raddr (upc_r),
        .rdata (uword_s)
    );

    assign seq_op_s    = seq_op_e'(uword_s[SEQ_OP_LSB +: 3]);
    assign next_addr_s = UPC_W'(uword_s[NEXT_ADDR_LSB +: 8]);
    assign ld_ir_s     = uword_s[LD_IR_BIT];
    assign wait_mem_s  = uword_s[WAIT_MEM_BIT];
    assign cw_s        = uword_s[CWR_W-1:0];

    assign stall_s   = (state_r == ST_RUN) && wait_mem_s && !bus.mem_ready;
    assign adv_s     = (state_r == ST_RUN) && !stall_s;
    assign upc_inc_s = upc_r + UPC_W'(1);
    // A word that loads IR dispatches on the opcode arriving in that same cycle.
    assign op_s      = ld_ir_s ? bus.mem_rdata[15:12] : ins_r[15:12];

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.run) state_nx_s = ST_RUN;
                else         state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (adv_s && seq_op_s == SEQ_HALT) state_nx_s = ST_HALT;
                else                               state_nx_s = ST_RUN;
            end
            ST_HALT: state_nx_s = ST_HALT;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy_s   = 1'b0;
        halted_s = 1'b0;
        cwr_s    = '0;
        case (state_r)
            ST_RUN: begin
                busy_s = 1'b1;
                if (stall_s) cwr_s = mask_rf_load(cw_s);
                else         cwr_s = cw_s;
            end
            ST_HALT: halted_s = 1'b1;
            default: cwr_s = '0;
        endcase
    end

    // Next upc / IR / retire count
    always_comb begin
        upc_nx_s     = upc_r;
        ins_nx_s     = ins_r;
        retired_nx_s = retired_r;
        if (state_r == ST_IDLE && bus.run) begin
            upc_nx_s = UPC_W'(FETCH_ADDR);
        end else if (adv_s) begin
            if (ld_ir_s) ins_nx_s = bus.mem_rdata;
            else         ins_nx_s = ins_r;
            case (seq_op_s)
                SEQ_JUMP:     upc_nx_s = next_addr_s;
                SEQ_DISPATCH: upc_nx_s = UPC_W'(int'(op_s) << DISPATCH_SHIFT);
                SEQ_BRZ:      upc_nx_s = bus.zero_flag  ? next_addr_s : upc_inc_s;
                SEQ_BRC:      upc_nx_s = bus.carry_flag ? next_addr_s : upc_inc_s;
                SEQ_FETCH: begin
                    upc_nx_s     = UPC_W'(FETCH_ADDR);
                    retired_nx_s = retired_r + 16'd1;
                end
                SEQ_HALT:     upc_nx_s = upc_r;
                default:      upc_nx_s = upc_inc_s;
            endcase
        end else begin
            upc_nx_s = upc_r;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_r     <= '0;
            ins_r     <= 16'h0000;
            retired_r <= 16'h0000;
        end else begin
            upc_r     <= upc_nx_s;
            ins_r     <= ins_nx_s;
            retired_r <= retired_nx_s;
        end
    end

    assign bus.upc     = upc_r;
    assign bus.ins     = ins_r;
    assign bus.retired = retired_r;
    assign bus.cwr     = cwr_s;
    assign bus.busy    = busy_s;
    assign bus.halted  = halted_s;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, hand-written wrap sequences
// and randomized cycles checked against a behavioural model of the sequencer.
module tb_micro_sequencer;

    logic clk = 1'b0;
    logic reset;

    micro_sequencer_if #(.UPC_W(8)) bus ();
    micro_sequencer #(.UPC_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    int    n_tests = 0;
    int    n_fail  = 0;
    string tag     = "init";

    // Reference model: microprogram image and architectural state
    int          rom_op [256];
    int          rom_na [256];
    int          rom_ld [256];
    int          rom_wm [256];
    logic [33:0] rom_cw [256];
    int          m_st;      // 0 idle, 1 run, 2 halt
    int          m_upc, m_ins, m_ret;

    typedef struct {
        logic        rst, run, mr;
        logic [15:0] rd;
        logic        zf, cf;
        logic [7:0]  e_upc;
        logic [15:0] e_ins, e_ret;
        logic        e_busy, e_halt;
    } vec_t;

    vec_t vt [23];

    function automatic vec_t v(input logic rst, run, mr, input logic [15:0] rd,
                               input logic zf, cf, input logic [7:0] eu,
                               input logic [15:0] ei, er, input logic eb, eh);
        vec_t t;
        t.rst = rst; t.run = run; t.mr = mr; t.rd = rd; t.zf = zf; t.cf = cf;
        t.e_upc = eu; t.e_ins = ei; t.e_ret = er; t.e_busy = eb; t.e_halt = eh;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, want 0x%0h", tag, name, act, exp);
        end
    endtask

    function automatic logic [33:0] cw_of(input int a);
        return 34'h3_0000_3000 | (34'(a) << 16) | 34'(a);
    endfunction

    function automatic void model_reset();
        m_st = 0; m_upc = 0; m_ins = 0; m_ret = 0;
    endfunction

    function automatic logic [33:0] exp_cwr(input logic mr);
        logic [33:0] c;
        if (m_st != 1) return 34'd0;
        c = rom_cw[m_upc];
        if (rom_wm[m_upc] != 0 && !mr) c[13:12] = 2'b00;
        return c;
    endfunction

    // Opcodes: 0 next, 1 jump, 2 dispatch, 3 brz, 4 brc, 5 fetch, 6 halt, 7 next
    function automatic void model_step(input logic r, ru, mr, input logic [15:0] rd,
                                       input logic zf, cf);
        int nxt, src;
        if (r) begin
            model_reset();
        end else if (m_st == 0) begin
            if (ru) begin m_st = 1; m_upc = 0; end
        end else if (m_st == 1 && !(rom_wm[m_upc] != 0 && !mr)) begin
            src = (rom_ld[m_upc] != 0) ? int'(rd) : m_ins;
            nxt = (m_upc + 1) % 256;
            case (rom_op[m_upc])
                1: nxt = rom_na[m_upc];
                2: nxt = (src / 4096) * 16;
                3: if (zf) nxt = rom_na[m_upc];
                4: if (cf) nxt = rom_na[m_upc];
                5: begin nxt = 0; m_ret = (m_ret + 1) % 65536; end
                6: begin nxt = m_upc; m_st = 2; end
                default: ;
            endcase
            m_ins = src;
            m_upc = nxt;
        end
    endfunction

    // Write one microword while the core is held in reset
    task automatic setw(input int a, input int op, input int na, input int ld, input int wm);
        reset           = 1'b1;
        bus.ucode_we    = 1'b1;
        bus.ucode_waddr = 8'(a);
        bus.ucode_wdata = {3'(op), 8'(na), 1'(ld), 1'(wm), cw_of(a)};
        rom_op[a] = op; rom_na[a] = na; rom_ld[a] = ld; rom_wm[a] = wm; rom_cw[a] = cw_of(a);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        bus.ucode_we = 1'b0;
    endtask

    // One cycle: drive, compare against the model before the edge, then clock both
    task automatic apply(input logic r, ru, mr, input logic [15:0] rd,
                         input logic zf, cf, input logic do_chk);
        reset          = r;
        bus.run        = ru;
        bus.mem_ready  = mr;
        bus.mem_rdata  = rd;
        bus.zero_flag  = zf;
        bus.carry_flag = cf;
        #1;
        if (do_chk) begin
            chk("cwr",     bus.cwr,     64'(exp_cwr(mr)));
            chk("upc",     bus.upc,     64'(m_upc));
            chk("ins",     bus.ins,     64'(m_ins));
            chk("retired", bus.retired, 64'(m_ret));
            chk("busy",    bus.busy,    64'(m_st == 1));
            chk("halted",  bus.halted,  64'(m_st == 2));
        end
        @(posedge clk);
        model_step(r, ru, mr, rd, zf, cf);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 16'h0000;
        bus.zero_flag = 1'b0; bus.carry_flag = 1'b0;
        bus.ucode_we = 1'b0; bus.ucode_waddr = 8'h00; bus.ucode_wdata = '0;
        model_reset();
        @(negedge clk);

        for (int a = 0; a < 256; a++) setw(a, 0, 0, 0, 0);
        setw(8'h00, 2, 8'h00, 1, 1);   // fetch + dispatch, waits on memory
        setw(8'h10, 1, 8'h22, 0, 0);
        setw(8'h22, 3, 8'h40, 0, 0);
        setw(8'h23, 4, 8'h50, 0, 0);
        setw(8'h40, 5, 8'h00, 0, 0);
        setw(8'h50, 6, 8'h00, 0, 0);
        setw(8'h24, 7, 8'h00, 0, 0);
        setw(8'h30, 2, 8'h00, 0, 0);
        setw(8'h60, 3, 8'h10, 0, 1);
        setw(8'h70, 6, 8'h00, 0, 1);
        setw(8'h80, 5, 8'h00, 1, 1);

        // rst run mr rd zf cf | upc ins retired busy halted (after the edge)
        vt[0]  = v(H, L, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, L, L);
        vt[1]  = v(H, H, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, L, L);
        vt[2]  = v(L, H, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, H, L);
        vt[3]  = v(L, L, H, 16'h1083, L, L, 8'h10, 16'h1083, 16'd0, H, L);
        vt[4]  = v(L, L, L, 16'h0000, L, L, 8'h22, 16'h1083, 16'd0, H, L);
        vt[5]  = v(L, L, L, 16'h0000, H, L, 8'h40, 16'h1083, 16'd0, H, L);
        vt[6]  = v(L, L, L, 16'h0000, L, L, 8'h00, 16'h1083, 16'd1, H, L);
        vt[7]  = v(L, L, L, 16'h2ABC, L, L, 8'h00, 16'h1083, 16'd1, H, L);
        vt[8]  = v(L, L, L, 16'h2ABC, L, L, 8'h00, 16'h1083, 16'd1, H, L);
        vt[9]  = v(L, L, L, 16'h2ABC, L, L, 8'h00, 16'h1083, 16'd1, H, L);
        vt[10] = v(L, L, H, 16'h2ABC, L, L, 8'h20, 16'h2ABC, 16'd1, H, L);
        vt[11] = v(L, H, L, 16'h0000, L, L, 8'h21, 16'h2ABC, 16'd1, H, L);
        vt[12] = v(L, L, L, 16'h0000, L, L, 8'h22, 16'h2ABC, 16'd1, H, L);
        vt[13] = v(L, L, L, 16'h0000, L, H, 8'h23, 16'h2ABC, 16'd1, H, L);
        vt[14] = v(L, L, L, 16'h0000, L, H, 8'h50, 16'h2ABC, 16'd1, H, L);
        vt[15] = v(L, L, L, 16'h0000, L, L, 8'h50, 16'h2ABC, 16'd1, L, H);
        vt[16] = v(L, H, L, 16'h0000, L, L, 8'h50, 16'h2ABC, 16'd1, L, H);
        vt[17] = v(H, L, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, L, L);
        vt[18] = v(L, H, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, H, L);
        vt[19] = v(L, L, H, 16'h4000, L, L, 8'h40, 16'h4000, 16'd0, H, L);
        vt[20] = v(L, L, L, 16'h0000, L, L, 8'h00, 16'h4000, 16'd1, H, L);
        vt[21] = v(L, L, L, 16'h0000, L, L, 8'h00, 16'h4000, 16'd1, H, L);
        vt[22] = v(H, L, L, 16'h0000, L, L, 8'h00, 16'h0000, 16'd0, L, L);

        tag = "table";
        for (int i = 0; i < 23; i++) begin
            apply(vt[i].rst, vt[i].run, vt[i].mr, vt[i].rd, vt[i].zf, vt[i].cf, 1'b1);
            chk($sformatf("v%0d.upc", i),     bus.upc,     64'(vt[i].e_upc));
            chk($sformatf("v%0d.ins", i),     bus.ins,     64'(vt[i].e_ins));
            chk($sformatf("v%0d.retired", i), bus.retired, 64'(vt[i].e_ret));
            chk($sformatf("v%0d.busy", i),    bus.busy,    64'(vt[i].e_busy));
            chk($sformatf("v%0d.halted", i),  bus.halted,  64'(vt[i].e_halt));
            if (i >= 7 && i <= 9)
                chk($sformatf("v%0d.stall_rf", i), bus.cwr[13:12], 64'(2'b00));
        end

        tag = "rand";
        for (int i = 0; i < 2000; i++) begin
            apply(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        end

        tag = "upc_wrap";
        setw(8'h00, 1, 8'hFE, 0, 0);
        apply(L, H, L, 16'h0000, L, L, 1'b1);
        apply(L, L, L, 16'h0000, L, L, 1'b1);
        chk("upc_fe", bus.upc, 64'(8'hFE));
        apply(L, L, L, 16'h0000, L, L, 1'b1);
        chk("upc_ff", bus.upc, 64'(8'hFF));
        apply(L, L, L, 16'h0000, L, L, 1'b1);
        chk("upc_00", bus.upc, 64'(8'h00));

        tag = "ret_wrap";
        setw(8'h00, 5, 8'h00, 0, 0);
        apply(L, H, L, 16'h0000, L, L, 1'b1);
        for (int i = 0; i < 65535; i++) apply(L, L, L, 16'h0000, L, L, 1'b0);
        chk("ret_ffff", bus.retired, 64'(16'hFFFF));
        apply(L, L, L, 16'h0000, L, L, 1'b1);
        chk("ret_0000", bus.retired, 64'(16'h0000));
        chk("upc_0", bus.upc, 64'(8'h00));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
